// File: rtl/four_by_four_node_patch_pkg.sv
// Shared definitions for the 4x4 damped wave-equation patch.
//   DW        data width, signed fixed-point 1.17 (0x20000 = 1.0 by convention)
//   IW        width of per-node intermediates (lap, t)
//   PW        width of the rho*lap product
//   DAMP_SH   damping shift, eta = 2^-DAMP_SH
//   sat_dw()  clamps a wide signed value into [MINV, MAXV]
package four_by_four_node_patch_pkg;

    localparam int N_SIDE  = 4;
    localparam int N_NODES = N_SIDE * N_SIDE;
    localparam int DW      = 18;
    localparam int IW      = 21;
    localparam int PW      = 39;
    localparam int FRAC    = 17;
    localparam int DAMP_SH = 10;

    localparam logic        [DW-1:0] ONE  = 18'h20000;
    localparam logic signed [DW-1:0] MAXV = 18'sh1FFFF;
    localparam logic signed [DW-1:0] MINV = -18'sh20000;

    function automatic logic signed [DW-1:0] sat_dw(input logic signed [PW-1:0] v);
        if (v > PW'(MAXV))
            return MAXV;
        else if (v < PW'(MINV))
            return MINV;
        else
            return v[DW-1:0];
    endfunction

endpackage

// File: rtl/four_by_four_node_patch_wave_node_update.sv
// Combinational single-node update of the damped 2-D wave equation.
//   u, u_prev          current and previous value of this node
//   r, l, up, dn       values of the four neighbours
//   rho                wave-speed coefficient (1.17)
//   nxt                saturated next value of this node
module wave_node_update
    import four_by_four_node_patch_pkg::*;
(
    input  logic signed [DW-1:0] u,
    input  logic signed [DW-1:0] u_prev,
    input  logic signed [DW-1:0] r,
    input  logic signed [DW-1:0] l,
    input  logic signed [DW-1:0] up,
    input  logic signed [DW-1:0] dn,
    input  logic signed [DW-1:0] rho,
    output logic signed [DW-1:0] nxt
);

    logic signed [IW-1:0] lap;
    logic signed [PW-1:0] p;
    logic signed [DW-1:0] rl;
    logic signed [IW-1:0] t;
    logic signed [IW-1:0] damped;

    always_comb begin
        lap    = IW'(r) + IW'(l) + IW'(up) + IW'(dn) - (IW'(u) <<< 2);
        p      = PW'(rho) * PW'(lap);
        // Arithmetic shift drops the fraction of the 1.17 x 1.17 product
        // with floor rounding; saturation keeps the 18-bit result from wrapping.
        rl     = sat_dw(p >>> FRAC);
        t      = IW'(rl) + (IW'(u) <<< 1) - IW'(u_prev);
        damped = t - (t >>> DAMP_SH);
        nxt    = sat_dw(PW'(damped));
    end

endmodule

// File: rtl/four_by_four_node_patch.sv
// One 4x4 tile of a damped 2-D wave-equation solver.
//   clock        rising-edge clock
//   reset        asynchronous active-low; loads init into u_cur and u_prev
//   enable       1 = advance one time step on this edge, 0 = hold
//   init         16 initial node values, index r*4+c
//   u_1_right    neighbour beyond column 3
//   u_1_left_1   neighbour beyond column 0
//   u_1_up_1     neighbour beyond row 0
//   u_1_down_1   neighbour beyond row 3
//   rho          wave-speed coefficient (1.17)
//   data_out     mean of the four interior nodes
//   middle       node (2,2) sign-extended to 32 bits
module four_by_four_node_patch
    import four_by_four_node_patch_pkg::*;
(
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [N_NODES-1:0][DW-1:0]     init,
    input  logic signed [DW-1:0]           u_1_right,
    input  logic signed [DW-1:0]           u_1_left_1,
    input  logic signed [DW-1:0]           u_1_up_1,
    input  logic signed [DW-1:0]           u_1_down_1,
    input  logic signed [DW-1:0]           rho,
    output logic signed [DW-1:0]           data_out,
    output logic signed [31:0]             middle
);

    logic signed [DW-1:0] u_cur  [N_NODES];
    logic signed [DW-1:0] u_prev [N_NODES];
    logic signed [DW-1:0] nxt    [N_NODES];
    logic signed [DW-1:0] nb_r   [N_NODES];
    logic signed [DW-1:0] nb_l   [N_NODES];
    logic signed [DW-1:0] nb_u   [N_NODES];
    logic signed [DW-1:0] nb_d   [N_NODES];
    logic signed [19:0]   isum;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < N_NODES; i++) begin
                u_cur[i]  <= init[i];
                u_prev[i] <= init[i];
            end
        end else if (enable) begin
            for (int unsigned i = 0; i < N_NODES; i++) begin
                u_cur[i]  <= nxt[i];
                u_prev[i] <= u_cur[i];
            end
        end
    end

    for (genvar gr = 0; gr < N_SIDE; gr++) begin : g_row
        for (genvar gc = 0; gc < N_SIDE; gc++) begin : g_col
            localparam int I = gr * N_SIDE + gc;

            if (gc == N_SIDE - 1) begin : g_r_edge
                assign nb_r[I] = u_1_right;
            end else begin : g_r_int
                assign nb_r[I] = u_cur[I+1];
            end

            if (gc == 0) begin : g_l_edge
                assign nb_l[I] = u_1_left_1;
            end else begin : g_l_int
                assign nb_l[I] = u_cur[I-1];
            end

            if (gr == 0) begin : g_u_edge
                assign nb_u[I] = u_1_up_1;
            end else begin : g_u_int
                assign nb_u[I] = u_cur[I-N_SIDE];
            end

            if (gr == N_SIDE - 1) begin : g_d_edge
                assign nb_d[I] = u_1_down_1;
            end else begin : g_d_int
                assign nb_d[I] = u_cur[I+N_SIDE];
            end

            wave_node_update u_node (
                .u      (u_cur[I]),
                .u_prev (u_prev[I]),
                .r      (nb_r[I]),
                .l      (nb_l[I]),
                .up     (nb_u[I]),
                .dn     (nb_d[I]),
                .rho    (rho),
                .nxt    (nxt[I])
            );
        end
    end

    // Four 18-bit values need 20 bits; the mean always fits back in 18.
    assign isum     = 20'(u_cur[5]) + 20'(u_cur[6]) + 20'(u_cur[9]) + 20'(u_cur[10]);
    assign data_out = DW'(isum >>> 2);
    assign middle   = 32'(u_cur[10]);

endmodule

// File: tb/tb_four_by_four_node_patch.sv
module tb_four_by_four_node_patch;

    logic                clock = 1'b0;
    logic                reset;
    logic                enable;
    logic [15:0][17:0]   init;
    logic signed [17:0]  u_1_right;
    logic signed [17:0]  u_1_left_1;
    logic signed [17:0]  u_1_up_1;
    logic signed [17:0]  u_1_down_1;
    logic signed [17:0]  rho;
    logic signed [17:0]  data_out;
    logic signed [31:0]  middle;

    int checks   = 0;
    int failures = 0;

    logic [17:0] exp_nodes [16];

    four_by_four_node_patch dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .init       (init),
        .u_1_right  (u_1_right),
        .u_1_left_1 (u_1_left_1),
        .u_1_up_1   (u_1_up_1),
        .u_1_down_1 (u_1_down_1),
        .rho        (rho),
        .data_out   (data_out),
        .middle     (middle)
    );

    always #5 clock = ~clock;

    task automatic set_sides(input logic [17:0] v);
        u_1_right  = v;
        u_1_left_1 = v;
        u_1_up_1   = v;
        u_1_down_1 = v;
    endtask

    task automatic fill_init(input logic [17:0] v);
        for (int unsigned i = 0; i < 16; i++) init[i] = v;
    endtask

    // Reset pulse placed between edges; returns with reset released, at negedge+2.
    task automatic do_reset();
        @(negedge clock);
        enable = 1'b0;
        reset  = 1'b0;
        #2;
        reset  = 1'b1;
    endtask

    // Advance n enabled steps; returns at a falling edge.
    task automatic step(input int unsigned n);
        @(negedge clock);
        enable = 1'b1;
        repeat (n) @(posedge clock);
        @(negedge clock);
        enable = 1'b0;
    endtask

    task automatic test_reset;
        fill_init(18'h0);
        set_sides(18'h0);
        rho = 18'h04000;
        do_reset();
        checks++;
        if (data_out !== 18'h0) begin
            failures++;
            $display("FAIL reset_data_out got=%h exp=%h", data_out, 18'h0);
        end
        checks++;
        if (middle !== 32'h0) begin
            failures++;
            $display("FAIL reset_middle got=%h exp=%h", middle, 32'h0);
        end
        step(20);
        checks++;
        if (data_out !== 18'h0) begin
            failures++;
            $display("FAIL zero_run_data_out got=%h exp=%h", data_out, 18'h0);
        end
        for (int unsigned i = 0; i < 16; i++) begin
            checks++;
            if (dut.u_cur[i] !== 18'h0) begin
                failures++;
                $display("FAIL zero_run_node%0d got=%h exp=%h", i, dut.u_cur[i], 18'h0);
            end
        end
    endtask

    task automatic load_impulse;
        fill_init(18'h0);
        init[5] = 18'h10000;
        set_sides(18'h0);
        rho = 18'h04000;
        do_reset();
    endtask

    task automatic test_impulse;
        load_impulse();
        checks++;
        if (data_out !== 18'h04000) begin
            failures++;
            $display("FAIL impulse_init_data_out got=%h exp=%h", data_out, 18'h04000);
        end
        step(1);
        for (int unsigned i = 0; i < 16; i++) exp_nodes[i] = 18'h0;
        exp_nodes[5] = 18'h07FE0;
        exp_nodes[1] = 18'h01FF8;
        exp_nodes[4] = 18'h01FF8;
        exp_nodes[6] = 18'h01FF8;
        exp_nodes[9] = 18'h01FF8;
        for (int unsigned i = 0; i < 16; i++) begin
            checks++;
            if (dut.u_cur[i] !== exp_nodes[i]) begin
                failures++;
                $display("FAIL impulse_step1_node%0d got=%h exp=%h", i, dut.u_cur[i], exp_nodes[i]);
            end
        end
        checks++;
        if (middle !== 32'h0) begin
            failures++;
            $display("FAIL impulse_step1_middle got=%h exp=%h", middle, 32'h0);
        end
        checks++;
        if (data_out !== 18'h02FF4) begin
            failures++;
            $display("FAIL impulse_step1_data_out got=%h exp=%h", data_out, 18'h02FF4);
        end
        step(1);
        checks++;
        if (dut.u_cur[5] !== 18'h3CFD9) begin
            failures++;
            $display("FAIL impulse_step2_node5 got=%h exp=%h", dut.u_cur[5], 18'h3CFD9);
        end
    endtask

    task automatic test_hold;
        load_impulse();
        repeat (10) @(negedge clock);
        checks++;
        if (data_out !== 18'h04000) begin
            failures++;
            $display("FAIL hold_data_out got=%h exp=%h", data_out, 18'h04000);
        end
        checks++;
        if (dut.u_cur[5] !== 18'h10000) begin
            failures++;
            $display("FAIL hold_node5 got=%h exp=%h", dut.u_cur[5], 18'h10000);
        end
        checks++;
        if (dut.u_cur[6] !== 18'h0) begin
            failures++;
            $display("FAIL hold_node6 got=%h exp=%h", dut.u_cur[6], 18'h0);
        end
    endtask

    task automatic test_symmetry;
        load_impulse();
        for (int unsigned k = 0; k < 8; k++) begin
            step(1);
            checks++;
            if (dut.u_cur[6] !== dut.u_cur[9]) begin
                failures++;
                $display("FAIL sym_12_21 step%0d got=%h exp=%h", k + 1, dut.u_cur[6], dut.u_cur[9]);
            end
            checks++;
            if (dut.u_cur[1] !== dut.u_cur[4]) begin
                failures++;
                $display("FAIL sym_01_10 step%0d got=%h exp=%h", k + 1, dut.u_cur[1], dut.u_cur[4]);
            end
        end
    endtask

    task automatic test_saturation;
        fill_init(18'h1FFFF);
        set_sides(18'h1FFFF);
        rho = 18'h08000;
        do_reset();
        checks++;
        if (data_out !== 18'h1FFFF) begin
            failures++;
            $display("FAIL sat_init_data_out got=%h exp=%h", data_out, 18'h1FFFF);
        end
        step(1);
        for (int unsigned i = 0; i < 16; i++) begin
            checks++;
            if (dut.u_cur[i] !== 18'h1FF80) begin
                failures++;
                $display("FAIL sat_flat_node%0d got=%h exp=%h", i, dut.u_cur[i], 18'h1FF80);
            end
        end
        checks++;
        if (middle !== 32'h0001FF80) begin
            failures++;
            $display("FAIL sat_flat_middle got=%h exp=%h", middle, 32'h0001FF80);
        end
        checks++;
        if (data_out !== 18'h1FF80) begin
            failures++;
            $display("FAIL sat_flat_data_out got=%h exp=%h", data_out, 18'h1FF80);
        end
    endtask

    // Large rho drives the corner updates past full scale in both directions.
    task automatic test_clamp;
        fill_init(18'h10000);
        set_sides(18'h1FFFF);
        rho = 18'h1FFFF;
        do_reset();
        step(1);
        checks++;
        if (dut.u_cur[0] !== 18'h1FFFF) begin
            failures++;
            $display("FAIL clamp_pos_node0 got=%h exp=%h", dut.u_cur[0], 18'h1FFFF);
        end
        checks++;
        if (dut.u_cur[15] !== 18'h1FFFF) begin
            failures++;
            $display("FAIL clamp_pos_node15 got=%h exp=%h", dut.u_cur[15], 18'h1FFFF);
        end
        checks++;
        if (dut.u_cur[1] !== 18'h1FF7F) begin
            failures++;
            $display("FAIL clamp_pos_node1 got=%h exp=%h", dut.u_cur[1], 18'h1FF7F);
        end
        checks++;
        if (middle !== 32'h0000FFC0) begin
            failures++;
            $display("FAIL clamp_pos_middle got=%h exp=%h", middle, 32'h0000FFC0);
        end
        checks++;
        if (data_out !== 18'h0FFC0) begin
            failures++;
            $display("FAIL clamp_pos_data_out got=%h exp=%h", data_out, 18'h0FFC0);
        end

        fill_init(18'h30000);
        set_sides(18'h20000);
        do_reset();
        step(1);
        checks++;
        if (dut.u_cur[0] !== 18'h20000) begin
            failures++;
            $display("FAIL clamp_neg_node0 got=%h exp=%h", dut.u_cur[0], 18'h20000);
        end
        checks++;
        if (dut.u_cur[1] !== 18'h20080) begin
            failures++;
            $display("FAIL clamp_neg_node1 got=%h exp=%h", dut.u_cur[1], 18'h20080);
        end
        checks++;
        if (middle !== 32'hFFFF0040) begin
            failures++;
            $display("FAIL clamp_neg_middle got=%h exp=%h", middle, 32'hFFFF0040);
        end
        checks++;
        if (data_out !== 18'h30040) begin
            failures++;
            $display("FAIL clamp_neg_data_out got=%h exp=%h", data_out, 18'h30040);
        end
    endtask

    task automatic test_reset_midrun;
        load_impulse();
        step(5);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if (data_out !== 18'h04000) begin
            failures++;
            $display("FAIL midrun_low_data_out got=%h exp=%h", data_out, 18'h04000);
        end
        checks++;
        if (dut.u_cur[5] !== 18'h10000) begin
            failures++;
            $display("FAIL midrun_low_node5 got=%h exp=%h", dut.u_cur[5], 18'h10000);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (data_out !== 18'h04000) begin
            failures++;
            $display("FAIL midrun_rel_data_out got=%h exp=%h", data_out, 18'h04000);
        end
        checks++;
        if (dut.u_cur[6] !== 18'h0) begin
            failures++;
            $display("FAIL midrun_rel_node6 got=%h exp=%h", dut.u_cur[6], 18'h0);
        end
        step(1);
        checks++;
        if (dut.u_cur[5] !== 18'h07FE0) begin
            failures++;
            $display("FAIL midrun_restep_node5 got=%h exp=%h", dut.u_cur[5], 18'h07FE0);
        end
        checks++;
        if (dut.u_cur[6] !== 18'h01FF8) begin
            failures++;
            $display("FAIL midrun_restep_node6 got=%h exp=%h", dut.u_cur[6], 18'h01FF8);
        end
    endtask

    initial begin
        reset  = 1'b0;
        enable = 1'b0;
        fill_init(18'h0);
        set_sides(18'h0);
        rho = 18'h04000;
        test_reset();
        test_impulse();
        test_hold();
        test_symmetry();
        test_saturation();
        test_clamp();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
